// File: rtl/rlwe_vec_lsu_if.sv
`default_nettype none
// ============================================================================
// Module   : rlwe_vec_lsu_if
// Purpose  : EXU command, data-memory and MPRF write-port signals of the LSU.
// Revision : 1.0 - initial release
// ============================================================================
interface rlwe_vec_lsu_if #(
  parameter int LANES = 8,
  parameter int XLEN  = 32
);
  logic                  exu2lsu_req;
  logic                  exu2lsu_cmd;
  logic [XLEN-1:0]       exu2lsu_addr;
  logic [XLEN-1:0]       exu2lsu_stride;
  logic [4:0]            exu2lsu_rd_addr;
  logic [LANES*XLEN-1:0] exu2lsu_st_data;
  logic                  lsu2exu_busy;
  logic                  lsu2exu_done;
  logic                  lsu2exu_err;
  logic                  lsu2dmem_req;
  logic                  lsu2dmem_cmd;
  logic [XLEN-1:0]       lsu2dmem_addr;
  logic [XLEN-1:0]       lsu2dmem_wdata;
  logic                  dmem2lsu_req_ack;
  logic [XLEN-1:0]       dmem2lsu_rdata;
  logic [1:0]            dmem2lsu_resp;
  logic                  lsu2mprf_w_req;
  logic [4:0]            lsu2mprf_rd_addr;
  logic                  lsu2mprf_rd_is_vector;
  logic [LANES*XLEN-1:0] lsu2mprf_rd_data;

  // master is the LSU itself; slave is the surrounding EXU, memory and MPRF
  modport master (
    input  exu2lsu_req, exu2lsu_cmd, exu2lsu_addr, exu2lsu_stride,
           exu2lsu_rd_addr, exu2lsu_st_data,
    output lsu2exu_busy, lsu2exu_done, lsu2exu_err,
    output lsu2dmem_req, lsu2dmem_cmd, lsu2dmem_addr, lsu2dmem_wdata,
    input  dmem2lsu_req_ack, dmem2lsu_rdata, dmem2lsu_resp,
    output lsu2mprf_w_req, lsu2mprf_rd_addr, lsu2mprf_rd_is_vector,
           lsu2mprf_rd_data
  );

  modport slave (
    output exu2lsu_req, exu2lsu_cmd, exu2lsu_addr, exu2lsu_stride,
           exu2lsu_rd_addr, exu2lsu_st_data,
    input  lsu2exu_busy, lsu2exu_done, lsu2exu_err,
    input  lsu2dmem_req, lsu2dmem_cmd, lsu2dmem_addr, lsu2dmem_wdata,
    output dmem2lsu_req_ack, dmem2lsu_rdata, dmem2lsu_resp,
    input  lsu2mprf_w_req, lsu2mprf_rd_addr, lsu2mprf_rd_is_vector,
           lsu2mprf_rd_data
  );
endinterface
`default_nettype wire

// File: rtl/rlwe_vec_lsu.sv
`default_nettype none
// ============================================================================
// Module   : rlwe_vec_lsu
// Purpose  : Strided vector load/store between data memory and the MPRF.
// Revision : 1.0 - initial release
// ============================================================================
module rlwe_vec_lsu #(
  parameter int LANES = 8,
  parameter int XLEN  = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  rlwe_vec_lsu_if.master bus
);
  localparam int            IW        = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IW-1:0] LAST_LANE = IW'(LANES - 1);
  localparam logic [1:0]    RESP_OK   = 2'b01;
  localparam logic [1:0]    RESP_ER   = 2'b10;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CHK  = 3'd1,
    REQ  = 3'd2,
    RESP = 3'd3,
    WB   = 3'd4
  } state_t;

  state_t                     state;
  logic                       cmd;
  logic [XLEN-1:0]            cur_addr;
  logic [XLEN-1:0]            stride;
  logic [4:0]                 rd;
  logic [IW-1:0]              lane;
  logic [LANES-1:0][XLEN-1:0] st_buf;
  logic [LANES-1:0][XLEN-1:0] ld_buf;
  logic [XLEN-1:0]            next_addr;
  logic [IW-1:0]              next_lane;

  // modulo-2^XLEN add: wrap-around and negative strides need no special case
  assign next_addr = cur_addr + stride;
  assign next_lane = lane + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                     <= IDLE;
      cmd                       <= 1'b0;
      cur_addr                  <= '0;
      stride                    <= '0;
      rd                        <= '0;
      lane                      <= '0;
      st_buf                    <= '0;
      ld_buf                    <= '0;
      bus.lsu2exu_busy          <= 1'b0;
      bus.lsu2exu_done          <= 1'b0;
      bus.lsu2exu_err           <= 1'b0;
      bus.lsu2dmem_req          <= 1'b0;
      bus.lsu2dmem_cmd          <= 1'b0;
      bus.lsu2dmem_addr         <= '0;
      bus.lsu2dmem_wdata        <= '0;
      bus.lsu2mprf_w_req        <= 1'b0;
      bus.lsu2mprf_rd_addr      <= '0;
      bus.lsu2mprf_rd_is_vector <= 1'b0;
      bus.lsu2mprf_rd_data      <= '0;
    end else begin
      bus.lsu2exu_done          <= 1'b0;
      bus.lsu2exu_err           <= 1'b0;
      bus.lsu2mprf_w_req        <= 1'b0;
      bus.lsu2mprf_rd_is_vector <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.exu2lsu_req) begin
            cmd              <= bus.exu2lsu_cmd;
            cur_addr         <= bus.exu2lsu_addr;
            stride           <= bus.exu2lsu_stride;
            rd               <= bus.exu2lsu_rd_addr;
            st_buf           <= bus.exu2lsu_st_data;
            lane             <= '0;
            bus.lsu2exu_busy <= 1'b1;
            state            <= CHK;
          end
        end
        CHK: begin
          if ((cur_addr[1:0] != 2'b00) || (stride[1:0] != 2'b00)) begin
            bus.lsu2exu_err  <= 1'b1;
            bus.lsu2exu_busy <= 1'b0;
            state            <= IDLE;
          end else begin
            bus.lsu2dmem_req   <= 1'b1;
            bus.lsu2dmem_cmd   <= cmd;
            bus.lsu2dmem_addr  <= cur_addr;
            bus.lsu2dmem_wdata <= st_buf[0];
            state              <= REQ;
          end
        end
        REQ: begin
          if (bus.dmem2lsu_req_ack) begin
            bus.lsu2dmem_req <= 1'b0;
            state            <= RESP;
          end
        end
        RESP: begin
          if (bus.dmem2lsu_resp == RESP_OK) begin
            if (!cmd) begin
              ld_buf[lane] <= bus.dmem2lsu_rdata;
            end
            if (lane == LAST_LANE) begin
              if (cmd) begin
                bus.lsu2exu_done <= 1'b1;
                bus.lsu2exu_busy <= 1'b0;
                state            <= IDLE;
              end else begin
                state <= WB;
              end
            end else begin
              lane               <= next_lane;
              cur_addr           <= next_addr;
              bus.lsu2dmem_req   <= 1'b1;
              bus.lsu2dmem_addr  <= next_addr;
              bus.lsu2dmem_wdata <= st_buf[next_lane];
              state              <= REQ;
            end
          end else if (bus.dmem2lsu_resp == RESP_ER) begin
            // the partially gathered buffer is simply never written back
            bus.lsu2exu_err  <= 1'b1;
            bus.lsu2exu_busy <= 1'b0;
            state            <= IDLE;
          end
        end
        WB: begin
          bus.lsu2mprf_w_req        <= 1'b1;
          bus.lsu2mprf_rd_addr      <= rd;
          bus.lsu2mprf_rd_is_vector <= 1'b1;
          bus.lsu2mprf_rd_data      <= ld_buf;
          bus.lsu2exu_done          <= 1'b1;
          bus.lsu2exu_busy          <= 1'b0;
          state                     <= IDLE;
        end
        default: begin
          bus.lsu2exu_busy <= 1'b0;
          state            <= IDLE;
        end
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_rlwe_vec_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_rlwe_vec_lsu
// Purpose  : Directed and randomized bench for rlwe_vec_lsu with a memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rlwe_vec_lsu;
  localparam int LANES = 8;
  localparam int XLEN  = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rlwe_vec_lsu_if #(.LANES(LANES), .XLEN(XLEN)) bus ();
  rlwe_vec_lsu #(.LANES(LANES), .XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // completion monitor
  int           done_cnt, err_cnt, w_cnt, both_bad, done_cyc, err_cyc, w_cyc;
  logic [255:0] w_data;
  logic [4:0]   w_rd;
  logic         w_vec;
  initial forever begin
    @(negedge clk);
    if (bus.lsu2exu_done) begin done_cnt++; done_cyc = cyc; end
    if (bus.lsu2exu_err)  begin err_cnt++;  err_cyc  = cyc; end
    if (bus.lsu2exu_done && bus.lsu2exu_err) both_bad++;
    if (bus.lsu2mprf_w_req) begin
      w_cnt++; w_cyc = cyc;
      w_data = bus.lsu2mprf_rd_data; w_rd = bus.lsu2mprf_rd_addr; w_vec = bus.lsu2mprf_rd_is_vector;
    end
  end

  // memory model: random ack/resp waits, read data = rd_base + lane index
  int          phase = 0, wcnt = 0, rcnt = 0, maxw = 0, errlane = -1, stall_at = -1, stab_bad = 0;
  logic [31:0] rd_base = 32'h0, seen_addr = 32'h0, seen_wdata = 32'h0;
  logic [31:0] q_addr[$];
  logic [31:0] q_wdata[$];
  logic        q_cmd[$];
  initial forever begin
    @(negedge clk);
    bus.dmem2lsu_req_ack = 1'b0;
    bus.dmem2lsu_resp    = 2'b00;
    bus.dmem2lsu_rdata   = 32'h0;
    if (!rst_n) begin
      phase = 0;
    end else if (phase == 2) begin
      if (q_addr.size() != stall_at) begin
        if (rcnt == 0) begin
          bus.dmem2lsu_resp  = (q_addr.size() - 1 == errlane) ? 2'b10 : 2'b01;
          bus.dmem2lsu_rdata = rd_base + 32'(q_addr.size() - 1);
          phase = 0;
        end else rcnt--;
      end
    end else if (bus.lsu2dmem_req) begin
      if (phase == 0) begin
        wcnt = int'($urandom_range(maxw, 0));
        seen_addr = bus.lsu2dmem_addr; seen_wdata = bus.lsu2dmem_wdata;
        phase = 1;
      end else if (bus.lsu2dmem_addr !== seen_addr || bus.lsu2dmem_wdata !== seen_wdata) begin
        stab_bad++;
      end
      if (wcnt == 0) begin
        bus.dmem2lsu_req_ack = 1'b1;
        q_addr.push_back(bus.lsu2dmem_addr);
        q_wdata.push_back(bus.lsu2dmem_wdata);
        q_cmd.push_back(bus.lsu2dmem_cmd);
        rcnt  = int'($urandom_range(maxw, 0));
        phase = 2;
      end else wcnt--;
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  int acc;
  task automatic start(input logic c, input logic [31:0] a, input logic [31:0] s, input logic [4:0] rd,
                       input logic [255:0] sd, input int mw, input int el, input logic [31:0] rb);
    q_addr.delete(); q_wdata.delete(); q_cmd.delete();
    done_cnt = 0; err_cnt = 0; w_cnt = 0; both_bad = 0; stab_bad = 0;
    maxw = mw; errlane = el; rd_base = rb;
    @(negedge clk);
    bus.exu2lsu_req = 1'b1; bus.exu2lsu_cmd = c; bus.exu2lsu_addr = a;
    bus.exu2lsu_stride = s; bus.exu2lsu_rd_addr = rd; bus.exu2lsu_st_data = sd;
    acc = cyc + 1;
    @(negedge clk);
    bus.exu2lsu_req = 1'b0;
    bus.exu2lsu_st_data = ~sd;
  endtask

  task automatic wait_end();
    int n = 0;
    while (done_cnt == 0 && err_cnt == 0 && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) begin
      checks++; errors++;
      $error("FAIL timeout observed=no completion expected=done or err");
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_xfer(input string tag, input logic c, input logic [31:0] a, input logic [31:0] s,
                            input logic [4:0] rd, input logic [255:0] sd, input int nexp,
                            input bit experr, input bit zw);
    logic [255:0] ev = '0;
    logic [31:0]  ea;
    chki({tag, " nreq"}, q_addr.size(), nexp);
    for (int i = 0; i < nexp && i < q_addr.size(); i++) begin
      ea = a + s * 32'(i);
      chk({tag, " addr"}, 256'(q_addr[i]), 256'(ea));
      chk({tag, " cmd"}, 256'(q_cmd[i]), 256'(c));
      if (c) chk({tag, " wdata"}, 256'(q_wdata[i]), 256'(sd[i*32 +: 32]));
    end
    chki({tag, " done_and_err"}, both_bad, 0);
    chki({tag, " req_stable"}, stab_bad, 0);
    if (experr) begin
      chki({tag, " err_cnt"}, err_cnt, 1);
      chki({tag, " done_cnt"}, done_cnt, 0);
      chki({tag, " w_cnt"}, w_cnt, 0);
    end else begin
      chki({tag, " done_cnt"}, done_cnt, 1);
      chki({tag, " err_cnt"}, err_cnt, 0);
      chki({tag, " w_cnt"}, w_cnt, c ? 0 : 1);
      if (!c) begin
        for (int i = 0; i < LANES; i++) ev[i*32 +: 32] = rd_base + 32'(i);
        chk({tag, " rd_data"}, w_data, ev);
        chk({tag, " rd_addr"}, 256'(w_rd), 256'(rd));
        chk({tag, " rd_is_vector"}, 256'(w_vec), 256'(1'b1));
        chki({tag, " done_with_wreq"}, w_cyc, done_cyc);
        if (zw) chki({tag, " load_latency"}, w_cyc - acc, 18);
      end else if (zw) begin
        chki({tag, " store_latency"}, done_cyc - acc, 17);
      end
    end
    chk({tag, " busy_after"}, 256'(bus.lsu2exu_busy), 256'(1'b0));
  endtask

  logic [255:0] sd;
  logic [31:0]  ra, rs;
  logic         rc;
  logic [4:0]   rr;
  int           n;

  initial begin
    #200000;
    $display("FAIL watchdog observed=time limit expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.exu2lsu_req = 1'b0; bus.exu2lsu_cmd = 1'b0; bus.exu2lsu_addr = '0;
    bus.exu2lsu_stride = '0; bus.exu2lsu_rd_addr = '0; bus.exu2lsu_st_data = '0;
    bus.dmem2lsu_req_ack = 1'b0; bus.dmem2lsu_rdata = '0; bus.dmem2lsu_resp = 2'b00;
    repeat (3) @(negedge clk);
    chk("reset ctrl", 256'({bus.lsu2exu_busy, bus.lsu2exu_done, bus.lsu2exu_err, bus.lsu2dmem_req,
                            bus.lsu2dmem_cmd, bus.lsu2dmem_addr, bus.lsu2dmem_wdata, bus.lsu2mprf_w_req,
                            bus.lsu2mprf_rd_addr, bus.lsu2mprf_rd_is_vector}), 256'(0));
    chk("reset rd_data", bus.lsu2mprf_rd_data, 256'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // zero-wait load, memory returns 0xA0+i
    start(1'b0, 32'h100, 32'h4, 5'd5, '0, 0, -1, 32'hA0);
    wait_end();
    check_xfer("load0", 1'b0, 32'h100, 32'h4, 5'd5, '0, 8, 1'b0, 1'b1);

    for (int i = 0; i < LANES; i++) sd[i*32 +: 32] = 32'h5500 + 32'(i);
    start(1'b1, 32'h200, 32'h10, 5'd0, sd, 0, -1, 32'h0);
    wait_end();
    check_xfer("store0", 1'b1, 32'h200, 32'h10, 5'd0, sd, 8, 1'b0, 1'b1);

    start(1'b1, 32'h200, 32'h10, 5'd0, sd, 3, -1, 32'h0);
    wait_end();
    check_xfer("store_wait", 1'b1, 32'h200, 32'h10, 5'd0, sd, 8, 1'b0, 1'b0);

    start(1'b0, 32'h102, 32'h4, 5'd1, '0, 0, -1, 32'h0);
    wait_end();
    check_xfer("mis_addr", 1'b0, 32'h102, 32'h4, 5'd1, '0, 0, 1'b1, 1'b0);
    chki("mis_addr err_latency_ok", int'(err_cyc - acc >= 1 && err_cyc - acc <= 2), 1);

    start(1'b0, 32'h100, 32'h6, 5'd1, '0, 0, -1, 32'h0);
    wait_end();
    check_xfer("mis_stride", 1'b0, 32'h100, 32'h6, 5'd1, '0, 0, 1'b1, 1'b0);
    chki("mis_stride err_latency_ok", int'(err_cyc - acc >= 1 && err_cyc - acc <= 2), 1);

    start(1'b0, 32'h400, 32'h8, 5'd9, '0, 2, 3, 32'h77);
    wait_end();
    check_xfer("bus_err", 1'b0, 32'h400, 32'h8, 5'd9, '0, 4, 1'b1, 1'b0);

    start(1'b0, 32'h480, 32'h4, 5'd10, '0, 1, -1, $urandom);
    wait_end();
    check_xfer("after_err", 1'b0, 32'h480, 32'h4, 5'd10, '0, 8, 1'b0, 1'b0);

    start(1'b0, 32'hFFFF_FFF8, 32'h4, 5'd11, '0, 1, -1, $urandom);
    wait_end();
    check_xfer("wrap", 1'b0, 32'hFFFF_FFF8, 32'h4, 5'd11, '0, 8, 1'b0, 1'b0);

    start(1'b0, 32'h40, 32'hFFFF_FFFC, 5'd0, '0, 0, -1, $urandom);
    wait_end();
    check_xfer("neg_stride", 1'b0, 32'h40, 32'hFFFF_FFFC, 5'd0, '0, 8, 1'b0, 1'b1);

    // a command pulsed while busy must be ignored
    start(1'b0, 32'h800, 32'h20, 5'd12, '0, 3, -1, $urandom);
    repeat (4) @(negedge clk);
    bus.exu2lsu_req = 1'b1; bus.exu2lsu_cmd = 1'b1; bus.exu2lsu_addr = 32'h900;
    @(negedge clk);
    bus.exu2lsu_req = 1'b0;
    wait_end();
    repeat (3) @(negedge clk);
    check_xfer("req_busy", 1'b0, 32'h800, 32'h20, 5'd12, '0, 8, 1'b0, 1'b0);

    // reset while waiting on the lane-5 response
    stall_at = 6;
    start(1'b0, 32'h300, 32'h8, 5'd7, '0, 0, -1, 32'h11);
    n = 0;
    while (!(phase == 2 && q_addr.size() == 6) && n < 200) begin @(negedge clk); n++; end
    chki("midrst reached_lane5", q_addr.size(), 6);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst ctrl", 256'({bus.lsu2exu_busy, bus.lsu2exu_done, bus.lsu2exu_err, bus.lsu2dmem_req,
                             bus.lsu2dmem_cmd, bus.lsu2dmem_addr, bus.lsu2dmem_wdata, bus.lsu2mprf_w_req,
                             bus.lsu2mprf_rd_addr, bus.lsu2mprf_rd_is_vector}), 256'(0));
    chk("midrst rd_data", bus.lsu2mprf_rd_data, 256'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stall_at = -1;
    repeat (5) @(negedge clk);
    chki("midrst no_more_req", q_addr.size(), 6);
    chki("midrst no_wreq", w_cnt, 0);
    chki("midrst no_done", done_cnt, 0);
    chk("midrst idle", 256'(bus.lsu2exu_busy), 256'(1'b0));

    start(1'b0, 32'h300, 32'h8, 5'd7, '0, 0, -1, 32'h11);
    wait_end();
    check_xfer("post_rst", 1'b0, 32'h300, 32'h8, 5'd7, '0, 8, 1'b0, 1'b1);

    for (int t = 0; t < 6; t++) begin
      rc = 1'($urandom_range(1, 0));
      ra = $urandom & 32'hFFFF_FFFC;
      rs = $urandom_range(1, 0) ? (32'($urandom_range(64, 0)) << 2) : (32'h0 - (32'($urandom_range(64, 1)) << 2));
      rr = 5'($urandom_range(31, 0));
      for (int i = 0; i < LANES; i++) sd[i*32 +: 32] = $urandom;
      start(rc, ra, rs, rr, sd, 3, -1, $urandom);
      wait_end();
      check_xfer("random", rc, ra, rs, rr, sd, 8, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
